gray_counter: RTL and testbench

- Parameterisable up/down counter whose registered output is Gray code.
- Sits directly upstream of the team's 4-bit Gray-to-binary converter and drives its gray input.
- Provides a glitch-free, single-bit-change sequence, suitable for crossing into other logic or for pointer generation.
- Keeps a binary state internally and registers its Gray encoding, so the output never glitches.

---
 rtl/gray_counter.sv | 94 +++++++++
 tb/tb_gray_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Purpose:
//   Up/down counter that keeps its count in binary and presents the registered
//   Gray encoding of that count. Because gray_out comes straight from a
//   flip-flop, it never glitches. Each enabled step changes exactly one bit of
//   gray_out, which makes it suitable as a pointer or clock-crossing source.
//   Its output feeds the 4-bit Gray-to-binary converter downstream.
//
// Parameters:
//   WIDTH     counter width in bits (minimum 2); both bin and gray_out use it
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      count enable, one step per cycle while high
//   up_dn     in   1      1 = increment, 0 = decrement (binary sense)
//   load      in   1      synchronous load strobe (has priority over en)
//   load_val  in   WIDTH  binary value to load
//   gray_out  out  WIDTH  registered Gray code of the current count
//   tc        out  1      registered terminal-count pulse
//
// Configuration macro:
//   GRAY_CNT_SAT_EN  when defined, the counter saturates at all-ones and at
//                    zero instead of wrapping. In that mode tc flags every
//                    cycle whose requested step was blocked. When undefined,
//                    the count wraps modulo 2^WIDTH and tc flags each wrap.
// -----------------------------------------------------------------------------
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_out,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_next;
   logic             tc_next;
   logic             at_limit;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // The step would leave the binary range. At that point the counter either
   // wraps or is blocked, depending on the build.
   assign at_limit = up_dn ? (bin == ALL_ONES) : (bin == ALL_ZERO);

   // Next-state selection with priority load > en > hold. tc is 0 unless
   // an enabled step hits the range limit.
   always_comb begin
      bin_next = bin;
      tc_next  = 1'b0;
      if (load) begin
         bin_next = load_val;
      end else if (en) begin
         if (at_limit) begin
            tc_next = 1'b1;
`ifdef GRAY_CNT_SAT_EN
            bin_next = bin;
`else
            bin_next = up_dn ? ALL_ZERO : ALL_ONES;
`endif
         end else begin
            bin_next = up_dn ? (bin + 1'b1) : (bin - 1'b1);
         end
      end
   end

   // gray_out is encoded from bin_next, so it tracks bin in the same cycle
   // without a combinational path to the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin      <= ALL_ZERO;
         gray_out <= ALL_ZERO;
         tc       <= 1'b0;
      end else begin
         bin      <= bin_next;
         gray_out <= to_gray(bin_next);
         tc       <= tc_next;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] gray_out;
   logic       tc;

   int errors = 0;
   int checks = 0;

   gray_counter #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .gray_out (gray_out),
      .tc       (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: binary count plus terminal-count flag.
   function automatic logic [4:0] model_next(input logic [3:0] b, input logic e,
                                             input logic u, input logic l,
                                             input logic [3:0] lv);
      logic [3:0] nb;
      logic       nt;
      nb = b;
      nt = 1'b0;
      if (l) nb = lv;
      else if (e && u) begin
         if (b == 4'd15) begin
            nt = 1'b1;
`ifdef GRAY_CNT_SAT_EN
            nb = 4'd15;
`else
            nb = 4'd0;
`endif
         end else nb = b + 4'd1;
      end else if (e && !u) begin
         if (b == 4'd0) begin
            nt = 1'b1;
`ifdef GRAY_CNT_SAT_EN
            nb = 4'd0;
`else
            nb = 4'd15;
`endif
         end else nb = b - 4'd1;
      end
      return {nt, nb};
   endfunction

   logic [3:0] up_seq [16];
   logic [3:0] prev;
   logic [3:0] ref_bin;
   logic [4:0] nxt;

   initial begin
      up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
      tick(); tick();
      chk4("reset_gray", gray_out, 4'b0000);
      chk1("reset_tc", tc, 1'b0);
      rst_n = 1'b1;

`ifndef GRAY_CNT_SAT_EN
      // Full up count with wrap.
      en = 1'b1; up_dn = 1'b1;
      prev = gray_out;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk4($sformatf("up_seq[%0d]", i), gray_out, up_seq[i]);
         chk1($sformatf("up_tc[%0d]", i), tc, (i == 15));
         checks++;
         assert ($countones(gray_out ^ prev) == 1) else begin
            errors++;
            $error("FAIL up_onebit[%0d]: observed=%b expected one bit from %b", i, gray_out, prev);
         end
         prev = gray_out;
      end

      // Down wrap from 0, then hold.
      up_dn = 1'b0;
      tick();
      chk4("down_wrap_gray", gray_out, 4'b1000);
      chk1("down_wrap_tc", tc, 1'b1);
      en = 1'b0;
      tick();
      chk4("hold_gray", gray_out, 4'b1000);
      chk1("hold_tc", tc, 1'b0);

      // A load wins over en. bin=15 with up would otherwise wrap.
      en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'b0101;
      tick();
      chk4("load_gray", gray_out, 4'b0111);
      chk1("load_tc", tc, 1'b0);
      load = 1'b0;
      tick();
      chk4("after_load_up", gray_out, 4'b0101);
      up_dn = 1'b0;
      tick();
      chk4("after_load_dn", gray_out, 4'b0111);

      // Count to gray 0110 (bin 4), then reset between edges with a load pending.
      load = 1'b1; load_val = 4'd3; up_dn = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk4("pre_reset_gray", gray_out, 4'b0110);
      load = 1'b1; load_val = 4'd9;
      #3 rst_n = 1'b0;
      #1;
      chk4("async_reset_gray", gray_out, 4'b0000);
      chk1("async_reset_tc", tc, 1'b0);
      #2 rst_n = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
      tick();
      chk4("post_reset_step", gray_out, 4'b0001);
`else
      // Saturation at the top.
      load = 1'b1; load_val = 4'b1111; en = 1'b1; up_dn = 1'b1;
      tick();
      chk4("sat_load_gray", gray_out, 4'b1000);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk4($sformatf("sat_up_gray[%0d]", i), gray_out, 4'b1000);
         chk1($sformatf("sat_up_tc[%0d]", i), tc, 1'b1);
      end
      up_dn = 1'b0;
      tick();
      chk4("sat_down_gray", gray_out, 4'b1001);
      chk1("sat_down_tc", tc, 1'b0);
      // Saturation at the bottom.
      load = 1'b1; load_val = 4'd0;
      tick();
      load = 1'b0;
      tick();
      chk4("sat_zero_gray", gray_out, 4'b0000);
      chk1("sat_zero_tc", tc, 1'b1);
`endif

      // Randomised run against the reference model.
      rst_n = 1'b0; load = 1'b0; en = 1'b0;
      #2 rst_n = 1'b1;
      ref_bin = 4'd0;
      for (int i = 0; i < 10000; i++) begin
         en       = ($urandom_range(0, 3) != 0);
         up_dn    = $urandom_range(0, 1);
         load     = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom_range(0, 15));
         nxt      = model_next(ref_bin, en, up_dn, load, load_val);
         prev     = gray_out;
         tick();
         ref_bin = nxt[3:0];
         chk4("rand_gray", gray_out, ref_bin ^ (ref_bin >> 1));
         chk1("rand_tc", tc, nxt[4]);
         if (!load && en && !nxt[4]) begin
            checks++;
            assert ($countones(gray_out ^ prev) == 1) else begin
               errors++;
               $error("FAIL rand_onebit: observed=%b expected one bit from %b", gray_out, prev);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
